// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI request arbiter.
//   arb_state_t : per-channel FSM state (IDLE / BUSY)
//   SIZE_8B     : AXI size code for 8-byte beats
//   rr_pick     : round-robin selection, returns a one-hot grant
//   onehot2idx  : one-hot vector to binary index
package axi_arb_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam logic [2:0]  SIZE_8B     = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First requesting index at or after ptr, wrapping at n-1 -> 0.
    // ptr < n and k < n, so a single conditional subtract replaces a modulo.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [2:0]             ptr,
        input logic [3:0]             n
    );
        logic [MAX_MASTERS-1:0] gnt;
        logic [3:0]             idx;
        gnt = '0;
        for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
            idx = {1'b0, ptr} + k[3:0];
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k[3:0] < n) && (gnt == '0) && req[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [2:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_arb_core.sv
// Single-channel arbitration core: IDLE/BUSY FSM, grant register, RR pointer.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-master request vector
//   done     : bridge reports final beat (ready & last)
//   cancel   : granted master dropped its request mid-burst
//   grant    : one-hot owner, zero while IDLE
//   busy     : channel is serving a burst
module axi_arb_core
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   done,
    input  logic                   cancel,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   busy
);

    arb_state_t             state, state_next;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_next, pick;
    logic [2:0]             ptr_q, ptr_next, gidx, ptr_adv;

    always_comb begin
        pick = '0;
        if (FIXED_PRIO != 0) begin
            // Ascending scan, so the highest requesting index is the last write.
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (req[i]) begin
                    pick    = '0;
                    pick[i] = 1'b1;
                end
            end
        end else begin
            pick = NUM_MASTERS'(rr_pick(MAX_MASTERS'(req), ptr_q, 4'(NUM_MASTERS)));
        end
    end

    assign gidx    = onehot2idx(MAX_MASTERS'(gnt_q));
    assign ptr_adv = (gidx == 3'(NUM_MASTERS - 1)) ? 3'd0 : gidx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            state <= state_next;
            gnt_q <= gnt_next;
            ptr_q <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        gnt_next   = gnt_q;
        ptr_next   = ptr_q;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = BUSY;
                    gnt_next   = pick;
                end
            end
            BUSY: begin
                if (done || cancel) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    ptr_next   = ptr_adv;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == BUSY);
        grant = busy ? gnt_q : '0;
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave arbiter in front of the AXI bridge. Independent read
// and write cores pick an owner per burst; this level only muxes the owner's
// request fields to the bridge and routes bridge responses back to it.
//   m_r_* / m_w_*         : per-master request fields (flattened, master i at slice i)
//   m_r_ready/last/data   : read responses (data broadcast, qualified by ready)
//   m_w_ready/last        : write responses
//   r_*_o / w_*_o         : request to bridge;  r_*_i / w_*_i : bridge response
//   r_grant_o / w_grant_o : one-hot current owner, zero when idle
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_r_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_r_addr,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_r_len,
    input  logic [NUM_MASTERS*3-1:0]          m_r_size,
    output logic [NUM_MASTERS-1:0]            m_r_ready,
    output logic [NUM_MASTERS-1:0]            m_r_last,
    output logic [DATA_WIDTH-1:0]             m_r_data,
    input  logic [NUM_MASTERS-1:0]            m_w_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_w_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_w_data,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_w_len,
    input  logic [NUM_MASTERS*3-1:0]          m_w_size,
    output logic [NUM_MASTERS-1:0]            m_w_ready,
    output logic [NUM_MASTERS-1:0]            m_w_last,
    output logic                              r_valid_o,
    output logic [ADDR_WIDTH-1:0]             r_addr_o,
    output logic [LEN_WIDTH-1:0]              r_len_o,
    output logic [2:0]                        r_size_o,
    input  logic                              r_ready_i,
    input  logic                              r_last_i,
    input  logic [DATA_WIDTH-1:0]             r_data_i,
    output logic                              w_valid_o,
    output logic [ADDR_WIDTH-1:0]             w_addr_o,
    output logic [DATA_WIDTH-1:0]             w_data_o,
    output logic [LEN_WIDTH-1:0]              w_len_o,
    output logic [2:0]                        w_size_o,
    input  logic                              w_ready_i,
    input  logic                              w_last_i,
    output logic [NUM_MASTERS-1:0]            r_grant_o,
    output logic [NUM_MASTERS-1:0]            w_grant_o
);

    logic [NUM_MASTERS-1:0] r_grant, w_grant;
    logic                   r_busy, w_busy;
    logic                   r_cancel, w_cancel;

    // Cancel: owner stopped requesting before the bridge signalled last.
    assign r_cancel = r_busy & ~(|(m_r_valid & r_grant));
    assign w_cancel = w_busy & ~(|(m_w_valid & w_grant));

    axi_arb_core #(
        .NUM_MASTERS (NUM_MASTERS),
        .FIXED_PRIO  (FIXED_PRIO)
    ) u_rd_core (
        .clk    (clk),
        .rst    (rst),
        .req    (m_r_valid),
        .done   (r_ready_i & r_last_i),
        .cancel (r_cancel),
        .grant  (r_grant),
        .busy   (r_busy)
    );

    axi_arb_core #(
        .NUM_MASTERS (NUM_MASTERS),
        .FIXED_PRIO  (FIXED_PRIO)
    ) u_wr_core (
        .clk    (clk),
        .rst    (rst),
        .req    (m_w_valid),
        .done   (w_ready_i & w_last_i),
        .cancel (w_cancel),
        .grant  (w_grant),
        .busy   (w_busy)
    );

    // Grants are zero while idle, so the muxes default every bridge output to 0.
    always_comb begin
        r_valid_o = 1'b0;
        r_addr_o  = '0;
        r_len_o   = '0;
        r_size_o  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                r_valid_o = m_r_valid[i];
                r_addr_o  = m_r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_len_o   = m_r_len[i*LEN_WIDTH +: LEN_WIDTH];
                r_size_o  = m_r_size[i*3 +: 3];
            end
        end
    end

    always_comb begin
        w_valid_o = 1'b0;
        w_addr_o  = '0;
        w_data_o  = '0;
        w_len_o   = '0;
        w_size_o  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_valid_o = m_w_valid[i];
                w_addr_o  = m_w_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_data_o  = m_w_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_len_o   = m_w_len[i*LEN_WIDTH +: LEN_WIDTH];
                w_size_o  = m_w_size[i*3 +: 3];
            end
        end
    end

    assign m_r_ready = r_grant & {NUM_MASTERS{r_ready_i}};
    assign m_r_last  = r_grant & {NUM_MASTERS{r_last_i}};
    assign m_r_data  = r_data_i;
    assign m_w_ready = w_grant & {NUM_MASTERS{w_ready_i}};
    assign m_w_last  = w_grant & {NUM_MASTERS{w_last_i}};
    assign r_grant_o = r_grant;
    assign w_grant_o = w_grant;

endmodule
